reg_share_arb: RTL

- Round-robin arbiter that shares one registered storage element (D-flop bank, width DATA_W) between N_REQ requesters.
- Each requester holds its write data and raises a request. The arbiter grants one requester at a time, captures that requester's data into the shared register, and tags it with the source index.
- An optional lock lets the owner perform a bounded burst of back-to-back writes before the arbiter releases the grant.

---
 rtl/reg_share_arb_pkg.sv | 13 +
 rtl/reg_share_arb_if.sv | 27 ++
 rtl/reg_share_arb_rr_pick.sv | 32 +++
 rtl/reg_share_arb.sv | 125 ++++++++++++
 4 files changed

// File: rtl/reg_share_arb_pkg.sv
// Shared types and default sizing for the round-robin shared-register arbiter.
package reg_share_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOCK = 4;

endpackage

// File: rtl/reg_share_arb_if.sv
// Requester-side bus of the arbiter: per-requester req/lock/wdata in,
// grant and shared register contents out. Master = requesters, slave = arbiter.
interface reg_share_arb_if #(
    parameter int N_REQ  = reg_share_arb_pkg::DEF_N_REQ,
    parameter int DATA_W = reg_share_arb_pkg::DEF_DATA_W
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  lock;
    logic [DATA_W-1:0] wdata [N_REQ];
    logic [N_REQ-1:0]  gnt;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic [IDX_W-1:0]  q_src;
    logic              busy;

    modport master (
        output req, lock, wdata,
        input  gnt, q, q_valid, q_src, busy
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, q_valid, q_src, busy
    );
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; the caller decides when the result is consumed.
module rr_pick #(
    parameter int N_REQ = reg_share_arb_pkg::DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);
    localparam int SW = IDX_W + 1;

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    wrapped;

    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0.
        rot     = N_REQ'({req, req} >> ptr);
        any_req = |req;
        off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum     = {1'b0, ptr} + {1'b0, off};
        wrapped = (sum >= SW'(N_REQ)) ? (sum - SW'(N_REQ)) : sum;
        winner  = IDX_W'(wrapped);
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin owner of one shared register; owner writes on the edge after grant,
// optional lock holds the grant for up to MAX_LOCK back-to-back writes.
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic           clk,
    input  logic           rst,
    reg_share_arb_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  next_ptr;
    logic              release_grant;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        lock_cnt_d    = lock_cnt_q;
        data_d        = data_q;
        src_d         = src_q;
        vld_d         = 1'b0;
        release_grant = 1'b0;
        // lock_cnt stays below MAX_LOCK while granted, so the increment cannot wrap.
        cnt_inc       = lock_cnt_q + CNT_W'(1);
        next_ptr      = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

        case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    gnt_d[winner] = 1'b1;
                    owner_d       = winner;
                    lock_cnt_d    = '0;
                    state_d       = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (bus.req[owner_q] && gnt_q[owner_q]) begin
                    data_d     = bus.wdata[owner_q];
                    src_d      = owner_q;
                    vld_d      = 1'b1;
                    lock_cnt_d = cnt_inc;
                    if (!(bus.lock[owner_q] && (cnt_inc < MAX_LOCK_C))) begin
                        release_grant = 1'b1;
                    end
                end else begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d == ARB_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            data_q     <= '0;
            src_q      <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            data_q     <= data_d;
            src_q      <= src_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = data_q;
    assign bus.q_valid = vld_q;
    assign bus.q_src   = src_q;
    assign bus.busy    = busy_q;

endmodule
